mem_sdram_bridge: RTL and testbench

Adapter between the main memory arbiter's downstream memory bus and one port of the SDRAM controller. The memory bus side uses mem_rd/mem_we/mem_busy with burstcount. The SDRAM side uses a toggle req/ack handshake.
The bridge splits long read bursts into controller-sized chunks and sequences write bursts beat by beat. It returns read data with a registered valid strobe, and it replaces the ad-hoc req/ack glue in memory test harnesses and the SoC top.

---
 rtl/mem_sdram_bridge.sv | 169 ++++++++++++++++
 tb/tb_mem_sdram_bridge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sdram_bridge.sv
// Bridge between the arbiter's memory bus and one toggle-handshake SDRAM controller port.
// Define BRIDGE_WRITE_POST_EN to post writes (busy only while the prior write is unacknowledged).
module mem_sdram_bridge #(
  parameter int MAX_BURST = 8,
  parameter int ADDR_W    = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_din,
  input  logic [3:0]        mem_be,
  input  logic [7:0]        mem_burstcount,
  input  logic              mem_rd,
  input  logic              mem_we,
  output logic              mem_busy,
  output logic [31:0]       mem_dout,
  output logic              mem_dout_ready,
  output logic              sdram_req,
  input  logic              sdram_ack,
  output logic              sdram_wr,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [31:0]       sdram_din,
  output logic [3:0]        sdram_be,
  output logic [3:0]        sdram_burst_cnt,
  input  logic [31:0]       sdram_dout,
  input  logic              sdram_ready,
  input  logic              sdram_burst_done
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK, WR_NEXT} state_t;

`ifdef BRIDGE_WRITE_POST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        remaining;
  logic [3:0]        beat;
  logic              issue_pend;

  logic              req_pending;
  logic [7:0]        rem_init, wr_rem, rem_after_chunk;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_accept, wr_accept, rd_beat, rd_last, rd_issue, wr_acked;
  state_t            wr_dest;

  // Address LSBs and upper bits are outside the SDRAM window; burst_done is informational.
  logic unused;
  assign unused = &{1'b0, sdram_burst_done, mem_addr};

  function automatic logic [3:0] chunk_len(input logic [7:0] rem);
    return (rem > 8'(MAX_BURST)) ? 4'(MAX_BURST) : rem[3:0];
  endfunction

  assign req_pending     = (sdram_req != sdram_ack);
  assign rem_init        = (mem_burstcount == 8'd0) ? 8'd1 : mem_burstcount;
  assign wr_rem          = (state == IDLE) ? rem_init : remaining;
  assign wr_addr         = (state == IDLE) ? mem_addr[ADDR_W-1:0] : addr + ADDR_W'(4);
  assign rem_after_chunk = remaining - {4'd0, sdram_burst_cnt};

  // Write wins over a simultaneous read; the read stays on the bus until the write burst ends.
  assign wr_accept = mem_we && !mem_busy && (state == IDLE || state == WR_NEXT);
  assign rd_accept = mem_rd && !mem_we && !mem_busy && (state == IDLE);
  assign rd_beat   = (state == RD_WAIT) && sdram_ready && !issue_pend;
  assign rd_last   = rd_beat && ((beat + 4'd1) == sdram_burst_cnt);
  assign rd_issue  = (state == RD_WAIT) && issue_pend && !req_pending;
  assign wr_acked  = (state == WR_ACK) && !req_pending;
  assign wr_dest   = POSTED ? ((wr_rem > 8'd1) ? WR_NEXT : IDLE) : WR_ACK;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_accept)      state_nxt = wr_dest;
        else if (rd_accept) state_nxt = RD_WAIT;
      end
      RD_WAIT: if (rd_last && rem_after_chunk == 8'd0) state_nxt = IDLE;
      WR_ACK:  if (wr_acked) state_nxt = (remaining > 8'd1) ? WR_NEXT : IDLE;
      WR_NEXT: if (wr_accept) state_nxt = wr_dest;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_busy = (state == RD_WAIT) || (state == WR_ACK);
`ifdef BRIDGE_WRITE_POST_EN
    if (req_pending) mem_busy = 1'b1;
`else
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: req resyncs to ack rather than to 0 so a reset never launches a phantom request.
      sdram_req       <= sdram_ack;
      sdram_wr        <= 1'b0;
      sdram_addr      <= '0;
      sdram_din       <= '0;
      sdram_be        <= '0;
      sdram_burst_cnt <= '0;
      mem_dout        <= '0;
      mem_dout_ready  <= 1'b0;
      addr            <= '0;
      remaining       <= '0;
      beat            <= '0;
      issue_pend      <= 1'b0;
    end else begin
      mem_dout_ready <= 1'b0;

      if (rd_accept) begin
        addr            <= mem_addr[ADDR_W-1:0];
        remaining       <= rem_init;
        beat            <= '0;
        issue_pend      <= 1'b0;
        sdram_req       <= ~sdram_req;
        sdram_wr        <= 1'b0;
        sdram_addr      <= mem_addr[ADDR_W-1:0];
        sdram_burst_cnt <= chunk_len(rem_init);
      end

      if (wr_accept) begin
        addr            <= wr_addr;
        remaining       <= POSTED ? wr_rem - 8'd1 : wr_rem;
        sdram_req       <= ~sdram_req;
        sdram_wr        <= 1'b1;
        sdram_addr      <= wr_addr;
        sdram_din       <= mem_din;
        sdram_be        <= mem_be;
        sdram_burst_cnt <= 4'd1;
      end

      if (rd_beat) begin
        mem_dout       <= sdram_dout;
        mem_dout_ready <= 1'b1;
        if (rd_last) begin
          beat      <= '0;
          remaining <= rem_after_chunk;
          if (rem_after_chunk != 8'd0) begin
            issue_pend <= 1'b1;
            addr       <= addr + ADDR_W'({sdram_burst_cnt, 2'b00});
          end
        end else begin
          beat <= beat + 4'd1;
        end
      end

      // The next chunk waits for the controller to have acknowledged the previous one.
      if (rd_issue) begin
        sdram_req       <= ~sdram_req;
        sdram_addr      <= addr;
        sdram_burst_cnt <= chunk_len(remaining);
        issue_pend      <= 1'b0;
      end

      if (wr_acked) remaining <= remaining - 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_sdram_bridge.sv
// Scoreboard bench for mem_sdram_bridge: an SDRAM port model checks requests, a monitor checks read data.
`timescale 1ns/1ps
module tb_mem_sdram_bridge;

  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       mem_addr, mem_din;
  logic [3:0]        mem_be;
  logic [7:0]        mem_burstcount;
  logic              mem_rd, mem_we;
  logic              mem_busy;
  logic [31:0]       mem_dout;
  logic              mem_dout_ready;
  logic              sdram_req, sdram_ack, sdram_wr;
  logic [ADDR_W-1:0] sdram_addr;
  logic [31:0]       sdram_din;
  logic [3:0]        sdram_be, sdram_burst_cnt;
  logic [31:0]       sdram_dout;
  logic              sdram_ready, sdram_burst_done;

  mem_sdram_bridge #(.MAX_BURST(8), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .mem_burstcount(mem_burstcount),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_busy(mem_busy),
    .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_wr(sdram_wr),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_be(sdram_be),
    .sdram_burst_cnt(sdram_burst_cnt), .sdram_dout(sdram_dout),
    .sdram_ready(sdram_ready), .sdram_burst_done(sdram_burst_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        cnt;
    logic [31:0]       din;
    logic [3:0]        be;
  } req_t;

  req_t        req_exp[$];
  logic [31:0] rd_exp[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          rd_delay = 2;
  int          wr_delay = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic req_t mk_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [3:0] cnt,
                                  input logic [31:0] din, input logic [3:0] be);
    req_t r;
    r.wr = wr; r.addr = a; r.cnt = cnt; r.din = din; r.be = be;
    return r;
  endfunction

  // SDRAM memory contents as seen by the port model.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a == 25'h100) ? 32'hDEADBEEF : (32'hA500_0000 ^ {7'd0, a});
  endfunction

  task automatic push_data(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) rd_exp.push_back(32'hA500_0000 ^ (base + 32'(4 * i)));
  endtask

  // SDRAM port model: checks each new request against the expected queue and answers it.
  initial begin
    req_t              e;
    logic [ADDR_W-1:0] a;
    int                n;
    sdram_ack = 1'b1; sdram_ready = 1'b0; sdram_dout = '0; sdram_burst_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset !== 1'b0 || sdram_req === sdram_ack) continue;
      a = sdram_addr;
      n = int'(sdram_burst_cnt);
      if (req_exp.size() == 0) begin
        check("req_unexpected", req_exp.size(), 1);
        sdram_ack = sdram_req;
        continue;
      end
      e = req_exp.pop_front();
      check("req_wr", {31'd0, sdram_wr}, {31'd0, e.wr});
      check("req_addr", {7'd0, sdram_addr}, {7'd0, e.addr});
      if (e.wr) begin
        check("req_din", sdram_din, e.din);
        check("req_be", {28'd0, sdram_be}, {28'd0, e.be});
        repeat (wr_delay) begin @(posedge clk); #1; end
        sdram_ack = ~sdram_ack;
      end else begin
        check("req_cnt", {28'd0, sdram_burst_cnt}, {28'd0, e.cnt});
        repeat (rd_delay) begin @(posedge clk); #1; end
        for (int i = 0; i < n; i++) begin
          sdram_ready      = 1'b1;
          sdram_dout       = mem_word(a + ADDR_W'(4 * i));
          sdram_burst_done = (i == n - 1);
          if (i == 0) sdram_ack = ~sdram_ack;
          @(posedge clk); #1;
        end
        sdram_ready = 1'b0; sdram_burst_done = 1'b0;
      end
    end
  end

  // Read-data monitor: every strobe must follow an sdram_ready by one cycle and match the queue.
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (mem_dout_ready === 1'b1) begin
      check("dout_latency", {31'd0, prev_ready}, 32'd1);
      if (rd_exp.size() == 0) check("dout_unexpected", rd_exp.size(), 1);
      else check("dout_data", mem_dout, rd_exp.pop_front());
    end
    prev_ready <= sdram_ready;
  end

  task automatic wait_not_busy(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!mem_busy) break;
      @(negedge clk);
    end
    check(name, {31'd0, mem_busy}, 32'd0);
  endtask

  task automatic wait_rd_done(input string name);
    for (int i = 0; i < 500 && rd_exp.size() != 0; i++) @(negedge clk);
    check(name, rd_exp.size(), 0);
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [7:0] bc);
    mem_rd = 1'b1; mem_addr = a; mem_burstcount = bc;
    @(negedge clk);
    mem_rd = 1'b0;
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, bad, seen, stall;
    reset = 1'b1; mem_rd = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_din = '0;
    mem_be = '0; mem_burstcount = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state; ack idles at 1 so req must have resynced to 1.
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    check("rst_dout_ready", {31'd0, mem_dout_ready}, 32'd0);
    check("rst_dout", mem_dout, 32'd0);
    check("rst_req", {31'd0, sdram_req}, 32'd1);
    check("rst_wr", {31'd0, sdram_wr}, 32'd0);
    check("rst_addr", {7'd0, sdram_addr}, 32'd0);
    check("rst_burst_cnt", {28'd0, sdram_burst_cnt}, 32'd0);

    // Single read with a 5-cycle controller latency.
    rd_delay = 5;
    req_exp.push_back(mk_req(1'b0, 25'h100, 4'd1, 32'd0, 4'd0));
    rd_exp.push_back(32'hDEADBEEF);
    issue_read(32'h100, 8'd1);
    for (int i = 0; i < 50; i++) begin
      if (mem_dout_ready) break;
      @(negedge clk);
    end
    check("t1_data", mem_dout, 32'hDEADBEEF);
    check("t1_busy_low", {31'd0, mem_busy}, 32'd0);

    // 20-beat read split into 8/8/4 chunks; busy high until the last strobe.
    rd_delay = 2;
    req_exp.push_back(mk_req(1'b0, 25'h1000, 4'd8, 32'd0, 4'd0));
    req_exp.push_back(mk_req(1'b0, 25'h1020, 4'd8, 32'd0, 4'd0));
    req_exp.push_back(mk_req(1'b0, 25'h1040, 4'd4, 32'd0, 4'd0));
    push_data(32'h1000, 20);
    issue_read(32'h1000, 8'd20);
    cnt = 0; bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (mem_dout_ready) cnt++;
      if (cnt == 20) break;
      if (!mem_busy) bad++;
      @(negedge clk);
    end
    check("t2_pulses", cnt, 20);
    check("t2_busy_held", bad, 0);
    check("t2_busy_end", {31'd0, mem_busy}, 32'd0);

    // 3-beat write burst; a read presented in WR_NEXT must be ignored.
    wr_delay = 3;
    req_exp.push_back(mk_req(1'b1, 25'h2000, 4'd0, 32'h1111_1111, 4'hF));
    req_exp.push_back(mk_req(1'b1, 25'h2004, 4'd0, 32'h2222_2222, 4'hF));
    req_exp.push_back(mk_req(1'b1, 25'h2008, 4'd0, 32'h3333_3333, 4'hF));
    for (int k = 0; k < 3; k++) begin
      wait_not_busy($sformatf("t3_wr_next%0d", k));
      if (k == 1) begin
        mem_rd = 1'b1; mem_addr = 32'h9000; mem_burstcount = 8'd1;
        @(negedge clk);
        check("t3_rd_ignored", {31'd0, mem_busy}, 32'd0);
        mem_rd = 1'b0;
      end
      mem_we = 1'b1; mem_burstcount = 8'd3; mem_be = 4'hF;
      mem_addr = (k == 0) ? 32'h2000 : 32'h0;
      mem_din = 32'h1111_1111 * (k + 1);
      @(negedge clk);
      mem_we = 1'b0;
      check($sformatf("t3_busy_wr_ack%0d", k), {31'd0, mem_busy}, 32'd1);
    end
    wait_not_busy("t3_idle");

    // Burstcount 0 read is one beat.
    req_exp.push_back(mk_req(1'b0, 25'h300, 4'd1, 32'd0, 4'd0));
    push_data(32'h300, 1);
    issue_read(32'h300, 8'd0);
    wait_rd_done("t4_bc0_done");
    wait_not_busy("t4_bc0_idle");

    // Read and write together: write issued first, held read follows.
    req_exp.push_back(mk_req(1'b1, 25'h400, 4'd0, 32'hCAFE_0001, 4'h3));
    req_exp.push_back(mk_req(1'b0, 25'h400, 4'd1, 32'd0, 4'd0));
    push_data(32'h400, 1);
    mem_rd = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_burstcount = 8'd1;
    mem_din = 32'hCAFE_0001; mem_be = 4'h3;
    @(negedge clk);
    mem_we = 1'b0;
    wait_not_busy("t4_wr_first_done");
    @(negedge clk);
    mem_rd = 1'b0;
    wait_rd_done("t4_rd_after_wr");
    wait_not_busy("t4_idle");

    // Reset after 2 of 8 beats: stale beats must not produce strobes.
    req_exp.push_back(mk_req(1'b0, 25'h5000, 4'd8, 32'd0, 4'd0));
    push_data(32'h5000, 2);
    issue_read(32'h5000, 8'd8);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (sdram_ready) seen++;
      if (seen == 2) break;
      @(negedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy", {31'd0, mem_busy}, 32'd0);
    check("t5_dout_ready", {31'd0, mem_dout_ready}, 32'd0);
    check("t5_dout", mem_dout, 32'd0);
    check("t5_req_eq_ack", {31'd0, sdram_req}, {31'd0, sdram_ack});
    repeat (10) @(negedge clk);
    check("t5_stale_dropped", rd_exp.size(), 0);
    req_exp.push_back(mk_req(1'b0, 25'h6000, 4'd2, 32'd0, 4'd0));
    push_data(32'h6000, 2);
    issue_read(32'h6000, 8'd2);
    wait_rd_done("t5_new_read");
    wait_not_busy("t5_idle");

`ifdef BRIDGE_WRITE_POST_EN
    // Posted writes: second single write stalls exactly until the first ack (4 cycles).
    wr_delay = 4;
    req_exp.push_back(mk_req(1'b1, 25'h7000, 4'd0, 32'hAAAA_0001, 4'hF));
    req_exp.push_back(mk_req(1'b1, 25'h7100, 4'd0, 32'hAAAA_0002, 4'hF));
    check("t6_first_busy", {31'd0, mem_busy}, 32'd0);
    mem_we = 1'b1; mem_addr = 32'h7000; mem_burstcount = 8'd1;
    mem_din = 32'hAAAA_0001; mem_be = 4'hF;
    @(negedge clk);
    mem_addr = 32'h7100; mem_din = 32'hAAAA_0002;
    stall = 0;
    for (int i = 0; i < 50; i++) begin
      if (!mem_busy) break;
      stall++;
      @(negedge clk);
    end
    check("t6_stall", stall, 4);
    @(negedge clk);
    mem_we = 1'b0;
    wait_not_busy("t6_done");
`else
    stall = 0;
`endif

    repeat (5) @(negedge clk);
    check("end_req_queue", req_exp.size(), 0);
    check("end_rd_queue", rd_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
